// File: rtl/hatch_pkg.sv
// Shared state encoding and scene codes for the incubation sequencer;
// the 8x8 dot-matrix driver imports the same scene constants.
package hatch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GROW    = 3'd1,
    CRACK   = 3'd2,
    HATCHED = 3'd3,
    FAIL    = 3'd4
  } hatch_state_e;

  localparam logic [3:0] SCN_GROW0   = 4'd0;
  localparam logic [3:0] SCN_GROW1   = 4'd1;
  localparam logic [3:0] SCN_GROW2   = 4'd2;
  localparam logic [3:0] SCN_GROW3   = 4'd3;
  localparam logic [3:0] SCN_GROW4   = 4'd4;
  localparam logic [3:0] SCN_GROW5   = 4'd5;
  localparam logic [3:0] SCN_CRACK_A = 4'd6;
  localparam logic [3:0] SCN_CRACK_B = 4'd7;
  localparam logic [3:0] SCN_ALARM   = 4'd8;
  localparam logic [3:0] SCN_CHICK_A = 4'd9;
  localparam logic [3:0] SCN_CHICK_B = 4'd10;
  localparam logic [3:0] SCN_FAIL    = 4'd11;

  function automatic logic [3:0] chickScene(input logic phase);
    return phase ? SCN_CHICK_B : SCN_CHICK_A;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second time base: counts CLK_HZ display-clock cycles and pulses tick
// in the last cycle of each second; clr forces a fresh second, hold freezes.
module sec_prescaler #(
  parameter int CLK_HZ = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int CW = $clog2(CLK_HZ) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] r_cnt;

  assign tick = !clr && !hold && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (!hold) begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hatch_scene_ctrl.sv
// Incubation sequencer feeding the dot-matrix driver: grow, crack, hatch on a
// 1 Hz base, with temperature alarm/fail. Define HATCH_PAUSE_EN for a pause input.
module hatch_scene_ctrl #(
  parameter int CLK_HZ    = 1000,
  parameter int STAGE_SEC = 3,
  parameter int CRACK_SEC = 2,
  parameter int FAIL_SEC  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       st,
  input  logic       temp_ok,
`ifdef HATCH_PAUSE_EN
  input  logic       pause,
`endif
  output logic [3:0] num,
  output logic       temp,
  output logic       st_out,
  output logic       done,
  output logic       fail
);

  import hatch_pkg::*;

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_GROW    = GROW;
  localparam logic [2:0] ST_CRACK   = CRACK;
  localparam logic [2:0] ST_HATCHED = HATCHED;
  localparam logic [2:0] ST_FAIL    = FAIL;

  localparam int SEC_MAX = (STAGE_SEC > CRACK_SEC) ? STAGE_SEC : CRACK_SEC;
  localparam int GW      = $clog2(SEC_MAX) + 1;
  localparam int BW      = $clog2(FAIL_SEC) + 1;
  localparam logic [GW-1:0] STAGE_LAST = GW'(STAGE_SEC - 1);
  localparam logic [GW-1:0] CRACK_LAST = GW'(CRACK_SEC - 1);
  localparam logic [BW-1:0] FAIL_LAST  = BW'(FAIL_SEC - 1);
  localparam logic [2:0]    LAST_STAGE = 3'd5;

  logic [2:0]    r_state;
  logic [2:0]    r_stage;
  logic [GW-1:0] r_good;
  logic [BW-1:0] r_bad;
  logic          r_frame;
  logic          r_chick;
  logic [3:0]    r_num;
  logic          r_temp;
  logic          r_stOut;
  logic          r_done;
  logic          r_fail;

  logic          w_tick;
  logic          w_pause;
  logic          w_clr;
  logic          w_inRun;
  logic [GW-1:0] w_secLast;
  logic [3:0]    w_num;
  logic          w_temp;

`ifdef HATCH_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_clr = !st || (r_state == ST_IDLE);

  sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .hold (w_pause),
    .tick (w_tick)
  );

  // Scene for the next output register; a low temp_ok overrides grow/crack art.
  always_comb begin
    w_inRun   = (r_state == ST_GROW) || (r_state == ST_CRACK);
    w_secLast = (r_state == ST_CRACK) ? CRACK_LAST : STAGE_LAST;
    w_num     = SCN_GROW0;
    w_temp    = 1'b1;
    case (r_state)
      ST_GROW: begin
        case (r_stage)
          3'd1:    w_num = SCN_GROW1;
          3'd2:    w_num = SCN_GROW2;
          3'd3:    w_num = SCN_GROW3;
          3'd4:    w_num = SCN_GROW4;
          3'd5:    w_num = SCN_GROW5;
          default: w_num = SCN_GROW0;
        endcase
      end
      ST_CRACK:   w_num = r_frame ? SCN_CRACK_B : SCN_CRACK_A;
      ST_HATCHED: w_num = chickScene(r_chick);
      ST_FAIL: begin
        w_num  = SCN_FAIL;
        w_temp = 1'b0;
      end
      default: ;
    endcase
    if (w_inRun && !temp_ok) begin
      w_num  = SCN_ALARM;
      w_temp = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stOut <= 1'b0;
    end else begin
      r_stOut <= st;
    end
  end

  // Bad seconds freeze progress instead of rewinding it; FAIL_SEC in a row is fatal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_stage <= '0;
      r_good  <= '0;
      r_bad   <= '0;
      r_frame <= 1'b0;
      r_chick <= 1'b0;
      r_num   <= SCN_GROW0;
      r_temp  <= 1'b1;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
    end else if (!st) begin
      r_state <= ST_IDLE;
      r_stage <= '0;
      r_good  <= '0;
      r_bad   <= '0;
      r_frame <= 1'b0;
      r_chick <= 1'b0;
      r_num   <= SCN_GROW0;
      r_temp  <= 1'b1;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
    end else if (!w_pause) begin
      r_num  <= w_num;
      r_temp <= w_temp;
      r_done <= (r_state == ST_HATCHED);
      r_fail <= (r_state == ST_FAIL);
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_GROW;
          r_stage <= '0;
          r_good  <= '0;
          r_bad   <= '0;
          r_frame <= 1'b0;
        end
        ST_GROW, ST_CRACK: begin
          if (w_tick) begin
            if (temp_ok) begin
              r_bad <= '0;
              if (r_good == w_secLast) begin
                r_good <= '0;
                if (r_state == ST_GROW) begin
                  if (r_stage == LAST_STAGE) begin
                    r_state <= ST_CRACK;
                    r_frame <= 1'b0;
                  end else begin
                    r_stage <= r_stage + 1'b1;
                  end
                end else if (!r_frame) begin
                  r_frame <= 1'b1;
                end else begin
                  r_state <= ST_HATCHED;
                  r_chick <= 1'b0;
                end
              end else begin
                r_good <= r_good + 1'b1;
              end
            end else if (r_bad == FAIL_LAST) begin
              r_state <= ST_FAIL;
            end else begin
              r_bad <= r_bad + 1'b1;
            end
          end
        end
        ST_HATCHED: begin
          if (w_tick) begin
            r_chick <= ~r_chick;
          end
        end
        default: ;
      endcase
    end
  end

  assign num    = r_num;
  assign temp   = r_temp;
  assign st_out = r_stOut;
  assign done   = r_done;
  assign fail   = r_fail;

endmodule
